// File: rtl/kernel_launch_pkg.sv
// rtl/kernel_launch_pkg.sv - shared types for the kernel launch sequencer
package kernel_launch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RESET = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ST_EXIT    = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_ABORT   = 2'd2
    } status_t;

    // Width of the shared phase counter (reset / warmup / drain lengths).
    localparam int PHASE_W = 32;

endpackage

// File: rtl/launch_down_counter.sv
// rtl/launch_down_counter.sv - loadable down counter with zero flag for phase timing
module launch_down_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    assign zero = (count == '0);

    // Reload on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (!zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/kernel_launch_ctrl.sv
// rtl/kernel_launch_ctrl.sv - start/done sequencer driving a CGRA kernel's reset, enable and arguments
module kernel_launch_ctrl
    import kernel_launch_pkg::*;
#(
    parameter int   WIDTH          = 32,
    parameter int   CNT_WIDTH      = 32,
    parameter int   RST_CYCLES     = 2,
    parameter int   WARMUP_CYCLES  = 1,
    parameter int   DRAIN_CYCLES   = 4,
    parameter int   TIMEOUT_CYCLES = 1024,
    parameter logic EXIT_VAL       = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     arg_a_in,
    input  logic [WIDTH-1:0]     arg_b_in,
    input  logic [WIDTH-1:0]     arg_c_in,
    input  logic                 exit_cond,
    output logic                 global_rst,
    output logic                 global_en,
    output logic [WIDTH-1:0]     arg_a,
    output logic [WIDTH-1:0]     arg_b,
    output logic [WIDTH-1:0]     arg_c,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    state_t               state;
    state_t               next_state;
    status_t              term_status;
    logic                 phase_zero;
    logic                 phase_load;
    logic [PHASE_W-1:0]   phase_val;
    logic                 exit_hit;
    logic                 timeout_hit;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 global_rst_d;
    logic                 global_en_d;
    logic                 busy_d;
    logic                 done_d;

    // Saturating increment: a runaway kernel must not wrap the count.
    assign cnt_inc     = (&cycle_count) ? cycle_count : cycle_count + 1'b1;
    // phase_zero in RUN means the warmup window is over.
    assign exit_hit    = phase_zero && (exit_cond == EXIT_VAL);
    // Fires on the RUN cycle whose completion brings the count to the limit.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (cnt_inc == CNT_WIDTH'(TIMEOUT_CYCLES));

    launch_down_counter #(
        .W (PHASE_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (phase_load),
        .load_val (phase_val),
        .zero     (phase_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and termination reason; abort beats exit beats timeout.
    always_comb begin
        next_state  = state;
        term_status = ST_EXIT;
        case (state)
            IDLE: begin
                if (start) next_state = RESET;
            end
            RESET: begin
                if (abort) begin
                    next_state  = DONE;
                    term_status = ST_ABORT;
                end else if (phase_zero) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state  = DONE;
                    term_status = ST_ABORT;
                end else if (exit_hit) begin
                    next_state  = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                    term_status = ST_EXIT;
                end else if (timeout_hit) begin
                    next_state  = DONE;
                    term_status = ST_TIMEOUT;
                end
            end
            DRAIN: begin
                if (abort) begin
                    next_state  = DONE;
                    term_status = ST_ABORT;
                end else if (phase_zero) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop; phase counter reload on entry.
    always_comb begin
        global_rst_d = (next_state == RESET);
        global_en_d  = (next_state == RUN) || (next_state == DRAIN);
        busy_d       = (next_state == RESET) || (next_state == RUN) || (next_state == DRAIN);
        done_d       = (next_state == DONE);
        phase_load   = (next_state != state);
        case (next_state)
            RESET:   phase_val = PHASE_W'(RST_CYCLES - 1);
            RUN:     phase_val = PHASE_W'(WARMUP_CYCLES);
            DRAIN:   phase_val = PHASE_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
            default: phase_val = '0;
        endcase
    end

    // Registered control outputs toward the kernel and host.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            global_rst <= 1'b0;
            global_en  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            global_rst <= global_rst_d;
            global_en  <= global_en_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Argument latch, enabled-cycle counter and termination status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arg_a       <= '0;
            arg_b       <= '0;
            arg_c       <= '0;
            status      <= 2'd0;
            cycle_count <= '0;
        end else if (state == IDLE && start) begin
            arg_a       <= arg_a_in;
            arg_b       <= arg_b_in;
            arg_c       <= arg_c_in;
            status      <= ST_EXIT;
            cycle_count <= '0;
        end else begin
            if (state == RUN || state == DRAIN) begin
                cycle_count <= cnt_inc;
            end
            if (next_state == DONE && state != DONE) begin
                status <= term_status;
            end
        end
    end

endmodule

// File: doc/kernel_launch_ctrl.md
Name: kernel_launch_ctrl

Overview:
Host-side sequencer driving the control end of a mapped CGRA kernel: generates the kernel's global_rst/global_en, holds the kernel's scalar IO arguments stable and watches the kernel's 1-bit loop-exit output.
Start/done handshake toward the host or testbench; reports run cycle count and termination status.
Sits between the host/test harness and the generated kernel top; one instance per kernel.

Parameters:
WIDTH, 32, width of scalar argument ports (matches kernel data width)
CNT_WIDTH, 32, width of cycle counter
RST_CYCLES, 2, cycles global_rst held high per launch (legal range >=1)
WARMUP_CYCLES, 1, initial RUN cycles during which exit_cond is ignored (0 = sample from first RUN cycle)
DRAIN_CYCLES, 4, extra enabled cycles after exit to flush kernel pipeline registers (0 allowed)
TIMEOUT_CYCLES, 1024, RUN cycle limit; 0 disables timeout
EXIT_VAL, 1'b1, exit_cond level that terminates the loop

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  launch request, sampled in IDLE only
abort  in  1  force termination, any busy state
arg_a_in, arg_b_in, arg_c_in  in  WIDTH each  scalar arguments, latched on accepted start
exit_cond  in  1  kernel loop-exit/branch output
global_rst  out  1  kernel reset
global_en  out  1  kernel enable
arg_a, arg_b, arg_c  out  WIDTH each  latched arguments to kernel IO inputs
busy  out  1  launch in progress
done  out  1  one-cycle completion pulse
status  out  2  0 = exit, 1 = timeout, 2 = abort; valid from done, held until next accepted start
cycle_count  out  CNT_WIDTH  enabled cycles (RUN+DRAIN) of last/current launch

Behaviour:
- All outputs registered. Async reset: state IDLE, every output 0 (including args, status, cycle_count).
- States: IDLE, RESET, RUN, DRAIN, DONE.
- IDLE: global_en=0, global_rst=0, busy=0. start=1 at edge k -> latch args, clear cycle_count and status; cycle k+1 enters RESET.
- RESET: global_rst=1, busy=1 for exactly RST_CYCLES cycles (k+1..k+RST_CYCLES), then RUN.
- RUN: global_en=1, global_rst=0; cycle_count += 1 per cycle, saturating at all-ones. exit_cond ignored during first WARMUP_CYCLES RUN cycles; thereafter exit_cond==EXIT_VAL -> DRAIN (status 0). Timeout: if TIMEOUT_CYCLES!=0 and cycle_count reaches TIMEOUT_CYCLES -> DONE directly (status 1), no drain.
- DRAIN: global_en=1 for DRAIN_CYCLES cycles, cycle_count keeps incrementing, exit_cond ignored; then DONE. DRAIN_CYCLES=0 -> RUN goes straight to DONE.
- DONE: single cycle; done=1, busy=0, global_en=0; next cycle IDLE. start during DONE ignored.
- Priority per cycle: abort > exit > timeout. Abort in RESET/RUN/DRAIN -> DONE, status 2, global_rst and global_en dropped in DONE cycle. Abort in IDLE/DONE ignored.
- start while busy ignored; args remain stable from latch until next accepted start (also across DONE/IDLE).
- exit_cond asserted during RESET/warmup has no effect.
- Async rst mid-launch: immediate return to IDLE with all outputs 0; no done pulse.

Decomposition:
- Package kernel_launch_pkg: state enum (IDLE, RESET, RUN, DRAIN, DONE), status codes (ST_EXIT=0, ST_TIMEOUT=1, ST_ABORT=2).
- One sub-module launch_down_counter: loadable down counter with zero flag, shared by RESET, warmup and DRAIN phases (reloaded on each state entry).

Test Plan:
- Defaults, start with args 0x100/0x200/0x0, exit_cond rises on RUN cycle 20 -> global_rst high 2 cycles, global_en high 24 cycles, done pulse, status 0, cycle_count 24, args stable throughout.
- exit_cond=1 during RESET and first RUN cycle, low afterwards until cycle 5 -> exit recognised only at cycle 5, cycle_count 9.
- TIMEOUT_CYCLES=16, exit_cond never asserted -> global_en high 16 cycles, done, status 1, cycle_count 16, no drain.
- abort on RUN cycle 3 -> next cycle DONE, global_en 0, status 2, cycle_count 3; abort in IDLE -> no effect.
- start pulsed during RUN and during DONE -> ignored, args unchanged; start in IDLE after done -> new launch, cycle_count cleared.
- Assert rst during DRAIN -> all outputs 0 immediately, no done; subsequent start launches normally.
